instr_fetch: RTL and testbench

- Fetch stage that sits directly downstream of the program counter register.
- Takes the current pc_val, issues a word read on the instruction-memory request/acknowledge bus, and holds the returned instruction for decode under a valid/ready handshake.
- Pulses pc_advance back to the PC so it steps to the next address.
- Handles redirect flushes, misaligned PCs and memory timeouts.

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus plus the decode valid/ready handshake.
// master is the fetch stage side; slave is the memory/decode side.
interface instr_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: reads the word at pc_val, holds it for decode, pulses pc_advance,
// and handles redirect flushes, misaligned PCs and memory timeouts.
module instr_fetch #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic [31:0]          pc_val,
    input  logic                 flush,
    output logic                 pc_advance,
    instr_fetch_if.master        bus,
    output logic                 fetch_fault,
    output logic [1:0]           fault_cause
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             pc_advance_q, pc_advance_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             fetch_fault_q, fetch_fault_d;
    logic [1:0]       fault_cause_q, fault_cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic pc_misaligned;
    assign pc_misaligned = (pc_val[1:0] != 2'b00);

    // State register and all output flops; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            pc_advance_q  <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            pc_advance_q  <= pc_advance_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fault_cause_q <= fault_cause_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        pc_advance_d  = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = fetch_fault_q;
        fault_cause_d = fault_cause_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    instr_d = NOP_INSTR;
                end else if (en) begin
                    if (pc_misaligned) begin
                        fetch_fault_d = 1'b1;
                        fault_cause_d = CAUSE_MISALGN;
                        state_d       = S_FAULT;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_val;
                        cnt_d      = '0;
                        state_d    = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (flush) begin
                    mem_req_d = 1'b0;
                    instr_d   = NOP_INSTR;
                    state_d   = S_IDLE;
                end else if (bus.mem_ack) begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    instr_d       = bus.mem_rdata;
                    instr_pc_d    = mem_addr_q;
                    instr_valid_d = 1'b1;
                    mem_req_d     = 1'b0;
                    pc_advance_d  = 1'b1;
                    state_d       = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d     = 1'b0;
                    fetch_fault_d = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                    state_d       = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (flush) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = S_IDLE;
                end else if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (!en) begin
                        state_d = S_IDLE;
                    end else if (pc_misaligned) begin
                        fetch_fault_d = 1'b1;
                        fault_cause_d = CAUSE_MISALGN;
                        state_d       = S_FAULT;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_val;
                        cnt_d      = '0;
                        state_d    = S_REQ;
                    end
                end
            end

            S_FAULT: begin
                mem_req_d     = 1'b0;
                instr_valid_d = 1'b0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign pc_advance      = pc_advance_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign fetch_fault     = fetch_fault_q;
    assign fault_cause     = fault_cause_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
module tb_instr_fetch;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic [31:0] pc_val;
    logic        flush;
    logic        pc_advance;
    logic        fetch_fault;
    logic [1:0]  fault_cause;

    instr_fetch_if bus ();

    instr_fetch #(.MEM_TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .pc_val      (pc_val),
        .flush       (flush),
        .pc_advance  (pc_advance),
        .bus         (bus.master),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: which activity the fetcher is engaged in, and what it shows.
    string       m_mode;       // "idle", "wait_mem", "show", "dead"
    int          m_waited;     // request cycles already spent without ack
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_adv;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_fault;
    logic [1:0]  m_cause;

    function automatic void m_reset();
        m_mode = "idle"; m_waited = 0; m_req = 0; m_addr = 0; m_adv = 0;
        m_instr = NOP; m_ipc = 0; m_valid = 0; m_fault = 0; m_cause = 2'b00;
    endfunction

    function automatic void m_start_or_fault(input logic [31:0] pc);
        if (pc % 4 != 0) begin
            m_mode = "dead"; m_fault = 1; m_cause = 2'b01;
        end else begin
            m_mode = "wait_mem"; m_req = 1; m_addr = pc; m_waited = 0;
        end
    endfunction

    function automatic void m_clock();
        m_adv = 0;
        if (clr) begin
            m_reset();
        end else if (m_mode == "idle") begin
            if (flush) m_instr = NOP;
            else if (en) m_start_or_fault(pc_val);
        end else if (m_mode == "wait_mem") begin
            if (flush) begin
                m_req = 0; m_instr = NOP; m_mode = "idle";
            end else if (bus.mem_ack) begin
                m_instr = bus.mem_rdata; m_ipc = m_addr; m_valid = 1;
                m_req = 0; m_adv = 1; m_mode = "show";
            end else if (m_waited + 1 == TO) begin
                m_req = 0; m_fault = 1; m_cause = 2'b10; m_mode = "dead";
            end else begin
                m_waited++;
            end
        end else if (m_mode == "show") begin
            if (flush) begin
                m_valid = 0; m_instr = NOP; m_mode = "idle";
            end else if (bus.instr_ready) begin
                m_valid = 0;
                if (en) m_start_or_fault(pc_val);
                else m_mode = "idle";
            end
        end
    endfunction

    // One clock: advance the model on the edge, then compare just after it.
    task automatic cyc();
        @(posedge clk);
        m_clock();
        #1;
        chk("mem_req", 32'(bus.mem_req), 32'(m_req));
        if (m_req) chk("mem_addr", bus.mem_addr, m_addr);
        chk("pc_advance", 32'(pc_advance), 32'(m_adv));
        chk("instr", bus.instr, m_instr);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        if (m_valid) chk("instr_pc", bus.instr_pc, m_ipc);
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("fault_cause", 32'(fault_cause), 32'(m_cause));
        if (bus.mem_req) begin
            chk("inv_adv_vs_req", 32'(pc_advance), 32'd0);
            chk("inv_addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
        end
    endtask

    logic [31:0] held_instr;
    logic [31:0] r;

    initial begin
        m_reset();
        clr = 1; en = 0; pc_val = 0; flush = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0; bus.instr_ready = 0;

        // Reset state
        cyc(); cyc();
        chk("rst_instr", bus.instr, NOP);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);

        // Basic fetch from 0
        clr = 0; en = 1; pc_val = 32'h0; bus.instr_ready = 1;
        cyc();
        chk("first_req", 32'(bus.mem_req), 32'd1);
        chk("first_addr", bus.mem_addr, 32'h0);
        bus.mem_ack = 1; bus.mem_rdata = 32'h0050_0093;
        cyc();
        chk("fetch_instr", bus.instr, 32'h0050_0093);
        chk("fetch_pc", bus.instr_pc, 32'h0);
        chk("fetch_valid", 32'(bus.instr_valid), 32'd1);
        chk("fetch_adv", 32'(pc_advance), 32'd1);
        bus.mem_ack = 0; pc_val = 32'h4;
        cyc();
        chk("next_req", 32'(bus.mem_req), 32'd1);
        chk("next_addr", bus.mem_addr, 32'h4);
        chk("adv_single", 32'(pc_advance), 32'd0);

        // Backpressure in HOLD
        bus.mem_ack = 1; bus.mem_rdata = 32'h00A0_0113;
        cyc();
        held_instr = bus.instr;
        chk("bp_instr", held_instr, 32'h00A0_0113);
        bus.mem_ack = 0; bus.instr_ready = 0; pc_val = 32'h8;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold_instr", bus.instr, 32'h00A0_0113);
            chk("bp_hold_pc", bus.instr_pc, 32'h4);
            chk("bp_no_req", 32'(bus.mem_req), 32'd0);
        end
        bus.instr_ready = 1;
        cyc();
        chk("bp_release_req", 32'(bus.mem_req), 32'd1);
        chk("bp_release_addr", bus.mem_addr, 32'h8);

        // Flush coincident with ack
        flush = 1; bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("fl_valid", 32'(bus.instr_valid), 32'd0);
        chk("fl_adv", 32'(pc_advance), 32'd0);
        chk("fl_instr", bus.instr, NOP);
        flush = 0; bus.mem_ack = 0; pc_val = 32'h100;
        cyc();
        chk("fl_redirect_addr", bus.mem_addr, 32'h100);

        // Timeout: first REQ cycle already visible, 15 more keep the request
        for (int i = 0; i < 15; i++) cyc();
        chk("to_still_req", 32'(bus.mem_req), 32'd1);
        cyc();
        chk("to_req_drop", 32'(bus.mem_req), 32'd0);
        chk("to_cause", 32'(fault_cause), 32'd2);

        // Ack on the 16th REQ cycle succeeds
        clr = 1; cyc(); clr = 0; pc_val = 32'h200;
        cyc();
        for (int i = 0; i < 15; i++) cyc();
        bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
        cyc();
        chk("to_edge_valid", 32'(bus.instr_valid), 32'd1);
        chk("to_edge_fault", 32'(fetch_fault), 32'd0);
        bus.mem_ack = 0;

        // Misaligned PC
        clr = 1; cyc(); clr = 0; pc_val = 32'h6;
        cyc();
        chk("mis_fault", 32'(fetch_fault), 32'd1);
        chk("mis_cause", 32'(fault_cause), 32'd1);
        pc_val = 32'h10;
        for (int i = 0; i < 3; i++) cyc();
        chk("mis_sticky", 32'(fetch_fault), 32'd1);
        chk("mis_no_req", 32'(bus.mem_req), 32'd0);

        // clr mid-request, late ack ignored
        clr = 1; cyc(); clr = 0;
        cyc();
        chk("clr_mid_req", 32'(bus.mem_req), 32'd1);
        clr = 1; cyc(); clr = 0; en = 0;
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_F00D;
        cyc();
        chk("clr_ack_valid", 32'(bus.instr_valid), 32'd0);
        chk("clr_ack_instr", bus.instr, NOP);
        chk("clr_ack_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            clr = (r[5:0] == 6'd0) || (m_fault && r[8:6] == 3'd0);
            en = (r[11:9] != 3'd0);
            flush = (r[15:12] == 4'd0);
            pc_val = {$urandom_range(0, 32'h3FFF_FFFF)} << 2;
            if (r[20:16] == 5'd0) pc_val[1:0] = 2'($urandom_range(1, 3));
            bus.mem_ack = ((i / 64) % 4 == 3) ? 1'b0 : r[21];
            bus.mem_rdata = $urandom;
            bus.instr_ready = (r[23:22] != 2'd0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
